// File: rtl/dcache_wb_pkg.sv
// dcache_wb_pkg
//   Shared types and constants for the L1 data-cache writeback buffer.
//   - LINE_OFFSET_BITS : byte-offset bits inside a 64-byte line
//   - wb_state_t       : drain FSM states
//   - wb_entry_t       : one buffered victim line (address + full line data)
//   - line_base()      : clears the line offset of an address
//   The entry layout is sized by WB_WIDTH / WB_LINE_WORDS; modules using the
//   entry must be built with matching WIDTH / LINE_WORDS.
package dcache_wb_pkg;

  localparam int LINE_OFFSET_BITS = 6;
  localparam int WB_WIDTH         = 64;
  localparam int WB_LINE_WORDS    = 8;
  localparam int WB_TAG_WIDTH     = 13;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ADDR,
    WB_DATA,
    WB_RESP
  } wb_state_t;

  typedef struct packed {
    logic [WB_WIDTH-1:0]               addr;
    logic [WB_WIDTH*WB_LINE_WORDS-1:0] data;
  } wb_entry_t;

  // Line-aligned address: the whole word is taken in and the offset masked
  // off, so callers never carry a half-used address vector around.
  function automatic logic [WB_WIDTH-1:0] line_base(input logic [WB_WIDTH-1:0] a);
    return a & ({WB_WIDTH{1'b1}} << LINE_OFFSET_BITS);
  endfunction

endpackage

// File: rtl/dcache_writeback_buffer_if.sv
// dcache_writeback_buffer_if
//   Writeback request/response bus between the writeback buffer and the
//   read/write arbiter.
//   - wb_reqcyc  : beat valid (buffer -> arbiter)
//   - wb_req     : line address on beat 0, data words on the following beats
//   - wb_reqtag  : writeback tag while wb_reqcyc, else 0
//   - wb_reqack  : arbiter accepted the current beat
//   - wb_respcyc : write completion from the memory side
//   - wb_respack : completion acknowledge, one-cycle pulse
//   modport master : buffer side; modport slave : arbiter side.
interface dcache_writeback_buffer_if #(
  parameter int WIDTH     = 64,
  parameter int TAG_WIDTH = 13
);
  logic                 wb_reqcyc;
  logic [WIDTH-1:0]     wb_req;
  logic [TAG_WIDTH-1:0] wb_reqtag;
  logic                 wb_reqack;
  logic                 wb_respcyc;
  logic                 wb_respack;

  modport master (
    output wb_reqcyc, wb_req, wb_reqtag, wb_respack,
    input  wb_reqack, wb_respcyc
  );

  modport slave (
    input  wb_reqcyc, wb_req, wb_reqtag, wb_respack,
    output wb_reqack, wb_respcyc
  );
endinterface

// File: rtl/dcache_wb_fifo.sv
// dcache_wb_fifo
//   Circular line store for the writeback buffer: storage, read/write
//   pointers, occupancy count and the victim-address match vector.
//   Ports:
//   - clk, reset        : clock, synchronous active-high reset
//   - push_i, entry_i   : write one line at the tail
//   - pop_i             : retire the head line
//   - head_o            : head entry (stable until popped)
//   - count_o           : occupied entries
//   - lookup_addr_i     : probe address, compared on the line-base bits
//   - lookup_hit_o      : probe matches any valid entry (combinational)
//   - lookup_data_o     : youngest matching line, 0 on miss
//                         (present only with DCACHE_WB_FORWARD_EN)
module dcache_wb_fifo
  import dcache_wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  push_i,
  input  wb_entry_t                             entry_i,
  input  logic                                  pop_i,
  output wb_entry_t                             head_o,
  output logic [CW-1:0]                         count_o,
  input  logic [WB_WIDTH-1:0]                   lookup_addr_i,
`ifdef DCACHE_WB_FORWARD_EN
  output logic [WB_WIDTH*WB_LINE_WORDS-1:0]     lookup_data_o,
`endif
  output logic                                  lookup_hit_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [DEPTH-1:0] valid, match;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: slot validity comes only from rd_ptr/count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= entry_i;
  end

  // A slot is live when its distance from the head is below count; the
  // subtraction wraps modulo DEPTH, which is what makes the ring work.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cam
    logic [PW-1:0] age;
    assign age      = PW'(i) - rd_ptr_q;
    assign valid[i] = CW'(age) < count_q;
    assign match[i] = valid[i] &&
                      (line_base(mem_q[i].addr) == line_base(lookup_addr_i));
  end

  assign lookup_hit_o = |match;
  assign head_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;

`ifdef DCACHE_WB_FORWARD_EN
  // Walk oldest to youngest so the last match seen (the youngest) wins;
  // with duplicate victims that is the most recent copy of the line.
  always_comb begin
    logic [PW-1:0] idx;
    idx           = '0;
    lookup_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (match[idx]) lookup_data_o = mem_q[idx].data;
    end
  end
`endif

endmodule

// File: rtl/dcache_writeback_buffer.sv
// dcache_writeback_buffer
//   Queues dirty lines evicted from the L1 data cache and drains them one
//   line at a time to the arbiter: address beat, LINE_WORDS data beats, then
//   wait for the write completion, acknowledge it and retire the line.
//   Optional feature macro: DCACHE_WB_FORWARD_EN adds lookup_data, the
//   youngest buffered copy of the probed line (0 on miss).
//   Ports:
//   - clk, reset                  : clock, synchronous active-high reset
//   - evict_valid / evict_ready   : eviction handshake (ready = count<DEPTH)
//   - evict_addr, evict_data      : victim line address and data (word 0 LSBs)
//   - wb                          : writeback bus, master side
//   - lookup_addr, lookup_hit     : miss probe against buffered lines
//   - lookup_data                 : forwarded line (DCACHE_WB_FORWARD_EN only)
//   - count                       : occupied entries
module dcache_writeback_buffer
  import dcache_wb_pkg::*;
#(
  parameter  int                   WIDTH      = WB_WIDTH,
  parameter  int                   TAG_WIDTH  = WB_TAG_WIDTH,
  parameter  int                   DEPTH      = 4,
  parameter  int                   LINE_WORDS = WB_LINE_WORDS,
  parameter  logic [TAG_WIDTH-1:0] WB_TAG     = 13'h0100,
  localparam int                   CW         = $clog2(DEPTH) + 1,
  localparam int                   BW         = $clog2(LINE_WORDS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          evict_valid,
  output logic                          evict_ready,
  input  logic [WIDTH-1:0]              evict_addr,
  input  logic [WIDTH*LINE_WORDS-1:0]   evict_data,
  dcache_writeback_buffer_if.master     wb,
  input  logic [WIDTH-1:0]              lookup_addr,
  output logic                          lookup_hit,
`ifdef DCACHE_WB_FORWARD_EN
  output logic [WIDTH*LINE_WORDS-1:0]   lookup_data,
`endif
  output logic [CW-1:0]                 count
);

  wb_state_t                        state_q, state_d;
  logic [BW-1:0]                    beat_q, beat_d, beat_nxt;
  logic                             reqcyc_q, reqcyc_d;
  logic [WIDTH-1:0]                 req_q, req_d;
  logic [TAG_WIDTH-1:0]             reqtag_q, reqtag_d;
  logic                             respack_q, respack_d;
  logic                             push, pop;
  logic [CW-1:0]                    cnt;
  wb_entry_t                        head, entry;
  logic [LINE_WORDS-1:0][WIDTH-1:0] words;

  // Ready comes straight from the registered count, so a full buffer never
  // accepts even when the head retires in the same cycle.
  assign evict_ready = cnt < CW'(DEPTH);
  assign push        = evict_valid && evict_ready;
  assign entry.addr  = evict_addr;
  assign entry.data  = evict_data;
  assign count       = cnt;

  dcache_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push),
    .entry_i       (entry),
    .pop_i         (pop),
    .head_o        (head),
    .count_o       (cnt),
    .lookup_addr_i (lookup_addr),
`ifdef DCACHE_WB_FORWARD_EN
    .lookup_data_o (lookup_data),
`endif
    .lookup_hit_o  (lookup_hit)
  );

  assign words    = head.data;
  assign beat_nxt = beat_q + 1'b1;

  // Bus outputs are registered: next-state logic below computes the value
  // each output must carry in the following cycle. The head entry cannot
  // change while it drains (pop only happens on completion), so it is safe
  // to read it at every transition.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    reqcyc_d  = reqcyc_q;
    req_d     = req_q;
    respack_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      WB_IDLE: begin
        if (cnt != '0) begin
          state_d  = WB_ADDR;
          reqcyc_d = 1'b1;
          req_d    = line_base(head.addr);
        end
      end
      WB_ADDR: begin
        if (wb.wb_reqack) begin
          state_d = WB_DATA;
          beat_d  = '0;
          req_d   = words[0];
        end
      end
      WB_DATA: begin
        if (wb.wb_reqack) begin
          if (beat_q == BW'(LINE_WORDS - 1)) begin
            state_d  = WB_RESP;
            reqcyc_d = 1'b0;
            req_d    = '0;
          end else begin
            beat_d = beat_nxt;
            req_d  = words[beat_nxt];
          end
        end
      end
      WB_RESP: begin
        // Completion retires the head in the same edge the ack is raised,
        // so the line stops hitting in lookups during the ack cycle.
        if (wb.wb_respcyc) begin
          state_d   = WB_IDLE;
          respack_d = 1'b1;
          pop       = 1'b1;
        end
      end
      default: state_d = WB_IDLE;
    endcase
    reqtag_d = reqcyc_d ? WB_TAG : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WB_IDLE;
      beat_q    <= '0;
      reqcyc_q  <= 1'b0;
      req_q     <= '0;
      reqtag_q  <= '0;
      respack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      reqcyc_q  <= reqcyc_d;
      req_q     <= req_d;
      reqtag_q  <= reqtag_d;
      respack_q <= respack_d;
    end
  end

  assign wb.wb_reqcyc  = reqcyc_q;
  assign wb.wb_req     = req_q;
  assign wb.wb_reqtag  = reqtag_q;
  assign wb.wb_respack = respack_q;

endmodule

// File: tb/tb_dcache_writeback_buffer.sv
// Self-checking bench for dcache_writeback_buffer: a per-cycle table for a
// single line, hand sequences for full / push-during-pop / mid-drain reset,
// and a randomized run against a queue-based line/beat model.
`timescale 1ns/1ps
module tb_dcache_writeback_buffer;
  localparam int W  = 64;
  localparam int TW = 13;
  localparam int D  = 4;
  localparam int LW = 8;
  localparam logic [TW-1:0] TAG = 13'h0100;

  logic              clk = 1'b0;
  logic              reset;
  logic              ev_valid, ev_ready;
  logic [W-1:0]      ev_addr;
  logic [W*LW-1:0]   ev_data;
  logic [W-1:0]      lk_addr;
  logic              lk_hit;
  logic [2:0]        cnt;
`ifdef DCACHE_WB_FORWARD_EN
  logic [W*LW-1:0]   lk_data;
`endif

  dcache_writeback_buffer_if #(.WIDTH(W), .TAG_WIDTH(TW)) wbif ();

  dcache_writeback_buffer #(
    .WIDTH(W), .TAG_WIDTH(TW), .DEPTH(D), .LINE_WORDS(LW), .WB_TAG(TAG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .evict_valid (ev_valid),
    .evict_ready (ev_ready),
    .evict_addr  (ev_addr),
    .evict_data  (ev_data),
    .wb          (wbif),
    .lookup_addr (lk_addr),
    .lookup_hit  (lk_hit),
`ifdef DCACHE_WB_FORWARD_EN
    .lookup_data (lk_data),
`endif
    .count       (cnt)
  );

  always #5 clk = ~clk;

  // Reference model: buffered lines in FIFO order, and the flat stream of
  // beats the arbiter must see (base address then 8 words per line).
  typedef struct { logic [W-1:0] addr; logic [W*LW-1:0] data; } line_t;
  line_t        mq[$];
  logic [W-1:0] beats_q[$];
  int           nbeat;
  bit           awaiting, exp_pack;
  bit           prev_cyc, prev_ack;
  logic [W-1:0] prev_req;
  int           n_tests, n_fail;

  typedef struct {
    bit ack; bit resp; bit cyc; logic [W-1:0] req; bit pack; int cnt; bit hit;
  } vec_t;
  vec_t vt[12];

  function automatic logic [W-1:0] lbase(input logic [W-1:0] a);
    return {a[W-1:6], 6'b0};
  endfunction

  function automatic logic [W*LW-1:0] rand_line();
    logic [W*LW-1:0] v;
    for (int i = 0; i < W*LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [W*LW-1:0] act, input logic [W*LW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act[127:0], exp[127:0]);
    end
  endtask

  task automatic check_outputs();
    bit hit;
    logic [W*LW-1:0] fd;
    hit = 0; fd = '0;
    foreach (mq[k]) if (lbase(mq[k].addr) == lbase(lk_addr)) begin hit = 1; fd = mq[k].data; end
    chk("count", cnt, mq.size());
    chk("evict_ready", ev_ready, mq.size() < D);
    chk("respack", wbif.wb_respack, exp_pack);
    if (wbif.wb_reqcyc) chk("reqtag_active", wbif.wb_reqtag, TAG);
    else                chk("reqtag_idle", wbif.wb_reqtag, 0);
    if (awaiting || mq.size() == 0) chk("reqcyc_quiet", wbif.wb_reqcyc, 0);
    if (prev_cyc && !prev_ack) begin
      chk("hold_reqcyc", wbif.wb_reqcyc, 1);
      chk("hold_req", wbif.wb_req, prev_req);
    end
    chk("lookup_hit", lk_hit, hit);
`ifdef DCACHE_WB_FORWARD_EN
    chk_line("lookup_data", lk_data, fd);
`endif
  endtask

  // One clock: update the model from the inputs now applied and the beat
  // now on the bus, cross the edge, then check every output.
  task automatic tick();
    bit push, xfer, pop;
    line_t ln;
    push = ev_valid && (mq.size() < D);
    xfer = wbif.wb_reqcyc && wbif.wb_reqack;
    pop  = awaiting && wbif.wb_respcyc;
    if (!reset) begin
      if (xfer) begin
        if (beats_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat: got %h expected no beat", wbif.wb_req);
        end else chk("beat", wbif.wb_req, beats_q.pop_front());
        nbeat++;
        if (nbeat == LW + 1) begin nbeat = 0; awaiting = 1; end
      end
      if (pop) begin void'(mq.pop_front()); awaiting = 0; end
      if (push) begin
        ln.addr = ev_addr; ln.data = ev_data;
        mq.push_back(ln);
        beats_q.push_back(lbase(ev_addr));
        for (int i = 0; i < LW; i++) beats_q.push_back(ev_data[i*W +: W]);
      end
    end
    exp_pack = pop && !reset;
    prev_cyc = wbif.wb_reqcyc; prev_ack = wbif.wb_reqack; prev_req = wbif.wb_req;
    @(posedge clk); #1;
    if (reset) begin
      mq.delete(); beats_q.delete();
      nbeat = 0; awaiting = 0; exp_pack = 0; prev_cyc = 0;
    end
    check_outputs();
  endtask

  task automatic drain(input string name);
    wbif.wb_reqack = 1; wbif.wb_respcyc = 1; ev_valid = 0;
    for (int c = 0; c < 300 && mq.size() != 0; c++) tick();
    chk({name, "_count"}, cnt, 0);
    chk({name, "_beats_left"}, beats_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W*LW-1:0] l1;
    n_tests = 0; n_fail = 0; nbeat = 0; awaiting = 0; exp_pack = 0; prev_cyc = 0;
    reset = 1; ev_valid = 0; ev_addr = '0; ev_data = '0; lk_addr = '0;
    wbif.wb_reqack = 0; wbif.wb_respcyc = 0;
    tick(); tick();
    chk("rst_reqcyc", wbif.wb_reqcyc, 0);
    chk("rst_req", wbif.wb_req, 0);
    chk("rst_reqtag", wbif.wb_reqtag, 0);
    chk("rst_respack", wbif.wb_respack, 0);
    chk("rst_hit", lk_hit, 0);
    chk("rst_count", cnt, 0);
    chk("rst_ready", ev_ready, 1);
    reset = 0;

    // ---- single line, reqack held high, table per cycle ----
    vt[0] = '{1'b1, 1'b0, 1'b1, 64'h1000_0040, 1'b0, 1, 1'b1};
    for (int k = 1; k <= 8; k++) vt[k] = '{1'b1, 1'b0, 1'b1, 64'hA0 + 64'(k - 1), 1'b0, 1, 1'b1};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1, 1'b1};  // completion during DATA is ignored
    vt[10] = '{1'b0, 1'b1, 1'b0, 64'h0, 1'b1, 0, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 0, 1'b0};
    for (int i = 0; i < LW; i++) l1[i*W +: W] = 64'hA0 + 64'(i);
    ev_addr = 64'h1000_0047; ev_data = l1; ev_valid = 1; lk_addr = 64'h1000_0070;
    tick();
    ev_valid = 0;
    chk("t1_latency_reqcyc", wbif.wb_reqcyc, 0);
    chk("t1_count_after_push", cnt, 1);
    lk_addr = 64'h1000_0010; #1;
    chk("t1_lookup_other_line", lk_hit, 0);
    lk_addr = 64'h1000_0070; #1;
    for (int r = 0; r < 12; r++) begin
      wbif.wb_reqack = vt[r].ack; wbif.wb_respcyc = vt[r].resp;
      tick();
      chk($sformatf("t1[%0d].reqcyc", r), wbif.wb_reqcyc, vt[r].cyc);
      chk($sformatf("t1[%0d].req", r), wbif.wb_req, vt[r].req);
      chk($sformatf("t1[%0d].respack", r), wbif.wb_respack, vt[r].pack);
      chk($sformatf("t1[%0d].count", r), cnt, vt[r].cnt);
      chk($sformatf("t1[%0d].hit", r), lk_hit, vt[r].hit);
`ifdef DCACHE_WB_FORWARD_EN
      if (vt[r].hit) chk_line($sformatf("t1[%0d].fwd", r), lk_data, l1);
`endif
    end

    // ---- fill with arbiter stalled, fifth offer refused, toggling drain ----
    wbif.wb_reqack = 0; wbif.wb_respcyc = 0;
    for (int k = 0; k < 4; k++) begin
      ev_valid = 1; ev_addr = 64'h2000_0000 + 64'(k * 64 + k); ev_data = rand_line();
      lk_addr = ev_addr;
      tick();
    end
    chk("full_count", cnt, 4);
    chk("full_ready", ev_ready, 0);
    ev_addr = 64'h2000_1000; ev_data = rand_line();
    tick(); tick();
    ev_valid = 0;
    chk("fifth_refused_count", cnt, 4);
    chk("stall_reqcyc", wbif.wb_reqcyc, 1);
    chk("stall_req", wbif.wb_req, 64'h2000_0000);
    wbif.wb_respcyc = 1;
    for (int c = 0; c < 400 && mq.size() != 0; c++) begin
      wbif.wb_reqack = c[0];
      tick();
    end
    chk("toggle_drain_count", cnt, 0);
    chk("toggle_drain_beats_left", beats_q.size(), 0);

    // ---- push in the pop cycle at count=2 ----
    wbif.wb_reqack = 1; wbif.wb_respcyc = 0;
    ev_valid = 1; ev_addr = 64'h4000_0100; ev_data = rand_line(); tick();
    ev_addr = 64'h4000_0200; ev_data = rand_line(); tick();
    ev_valid = 0;
    for (int c = 0; c < 50 && !awaiting; c++) tick();
    chk("pp_reached_resp", awaiting, 1);
    chk("pp_count_before", cnt, 2);
    ev_valid = 1; ev_addr = 64'h4000_0300; ev_data = rand_line(); wbif.wb_respcyc = 1;
    tick();
    ev_valid = 0; wbif.wb_respcyc = 0;
    chk("pp_count_same", cnt, 2);
    chk("pp_respack", wbif.wb_respack, 1);
    drain("pp_drain");

    // ---- reset while beat 3 is on the bus ----
    l1 = rand_line();
    wbif.wb_reqack = 1; wbif.wb_respcyc = 0;
    ev_valid = 1; ev_addr = 64'h5000_0000; ev_data = l1; tick();
    ev_valid = 0;
    for (int c = 0; c < 20 && nbeat < 4; c++) tick();
    chk("mid_beat3", wbif.wb_req, l1[3*W +: W]);
    reset = 1; tick(); reset = 0;
    chk("mid_rst_reqcyc", wbif.wb_reqcyc, 0);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_ready", ev_ready, 1);
    tick();
    chk("mid_rst_no_resume", wbif.wb_reqcyc, 0);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 1500; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      ev_valid = ($urandom_range(0, 9) < 4);
      ev_addr  = 64'h3000_0000 + 64'($urandom_range(0, 5)) * 64 + 64'($urandom_range(0, 63));
      ev_data  = rand_line();
      lk_addr  = 64'h3000_0000 + 64'($urandom_range(0, 7)) * 64 + 64'($urandom_range(0, 63));
      wbif.wb_reqack  = ($urandom_range(0, 9) < 6);
      wbif.wb_respcyc = ($urandom_range(0, 9) < 4);
      tick();
    end
    reset = 0;
    drain("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
